tx_pipe_arbiter: RTL

Two-source, frame-granular round-robin arbiter that shares the single TX FIFO pipe write port (the MAC transmit buffer feeding the AXIS Tx interface) between two AHIR pipe producers, e.g. the NIC DMA queue and a control/loopback frame generator. It locks onto one source for a whole frame, terminated by the tlast bit in the pipe word, so frames never interleave in the TX FIFO. It also keeps per-source frame counters for debug.

---
 rtl/tx_pipe_arbiter_pkg.sv | 28 ++
 rtl/tx_pipe_arbiter_rr_pick2.sv | 21 ++
 rtl/tx_pipe_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/tx_pipe_arbiter_pkg.sv
// Shared definitions for the TX/RX pipe arbitration blocks: default pipe
// word geometry, arbiter state encoding and pipe-word field helpers.
package tx_pipe_arbiter_pkg;

  localparam int DEF_MAC_WIDTH   = 8;
  localparam int DEF_TKEEP_WIDTH = 1;
  localparam int DEF_CNT_WIDTH   = 16;

  // Arbiter state encoding, shared with the rx-side modules.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Pipe word layout: {tlast, data[MAC_WIDTH-1:0], keep[TKEEP_WIDTH-1:0]}.
  function automatic int tlast_bit(input int nic_width);
    return nic_width - 1;
  endfunction

  function automatic int data_lsb(input int tkeep_width);
    return tkeep_width;
  endfunction

  function automatic int data_msb(input int nic_width);
    return nic_width - 2;
  endfunction

endpackage

// File: rtl/tx_pipe_arbiter_rr_pick2.sv
// Combinational 2-way round-robin pick: a lone requester wins outright,
// on contention the source that did not win last time gets the grant.
module tx_pipe_arbiter_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  // Winner selection with round-robin tie break.
  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last_grant;
    end else begin
      winner = req[1];
    end
  end

endmodule

// File: rtl/tx_pipe_arbiter.sv
// Frame-granular two-source arbiter for the TX FIFO pipe write port.
// Locks onto one producer from its first word until the word carrying
// tlast is accepted, so frames never interleave in the TX FIFO.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no frame owned; all acks low; pick a winner from pending reqs
// ST_LOCKED | granted source wired straight through to the TX FIFO port
module tx_pipe_arbiter
  import tx_pipe_arbiter_pkg::*;
#(
  parameter int MAC_WIDTH   = DEF_MAC_WIDTH,
  parameter int TKEEP_WIDTH = DEF_TKEEP_WIDTH,
  parameter int NIC_WIDTH   = MAC_WIDTH + TKEEP_WIDTH + 1,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NIC_WIDTH-1:0] src0_pipe_write_data,
  input  logic                 src0_pipe_write_req,
  output logic                 src0_pipe_write_ack,
  input  logic [NIC_WIDTH-1:0] src1_pipe_write_data,
  input  logic                 src1_pipe_write_req,
  output logic                 src1_pipe_write_ack,
  output logic [NIC_WIDTH-1:0] TX_FIFO_pipe_write_data,
  output logic                 TX_FIFO_pipe_write_req,
  input  logic                 TX_FIFO_pipe_write_ack,
  output logic                 busy,
  output logic                 grant,
  output logic [CNT_WIDTH-1:0] frame_count0,
  output logic [CNT_WIDTH-1:0] frame_count1
);

  localparam int TLAST = tlast_bit(NIC_WIDTH);

  arb_state_e           state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
  logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;

  logic                 pick_valid;
  logic                 pick_winner;
  logic [NIC_WIDTH-1:0] sel_data;
  logic                 sel_req;
  logic                 last_xfer;

  tx_pipe_arbiter_rr_pick2 u_pick (
    .req        ({src1_pipe_write_req, src0_pipe_write_req}),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Source mux keyed by the registered grant; req never depends on the FIFO ack.
  always_comb begin
    sel_data  = grant_q ? src1_pipe_write_data : src0_pipe_write_data;
    sel_req   = grant_q ? src1_pipe_write_req  : src0_pipe_write_req;
    last_xfer = (state_q == ST_LOCKED) && sel_req && TX_FIFO_pipe_write_ack
                && sel_data[TLAST];
  end

  // Next-state, grant bookkeeping, frame counting and port steering.
  always_comb begin
    state_d                 = state_q;
    grant_d                 = grant_q;
    last_grant_d            = last_grant_q;
    cnt0_d                  = cnt0_q;
    cnt1_d                  = cnt1_q;
    TX_FIFO_pipe_write_data = '0;
    TX_FIFO_pipe_write_req  = 1'b0;
    src0_pipe_write_ack     = 1'b0;
    src1_pipe_write_ack     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_winner;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        TX_FIFO_pipe_write_data = sel_data;
        TX_FIFO_pipe_write_req  = sel_req;
        if (grant_q) begin
          src1_pipe_write_ack = TX_FIFO_pipe_write_ack;
        end else begin
          src0_pipe_write_ack = TX_FIFO_pipe_write_ack;
        end
        // Frame ends only when the tlast word is actually accepted.
        if (last_xfer) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
          if (grant_q) begin
            cnt1_d = cnt1_q + CNT_WIDTH'(1);
          end else begin
            cnt0_d = cnt0_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers; last_grant resets to 1 so source 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign busy         = (state_q == ST_LOCKED);
  assign grant        = grant_q;
  assign frame_count0 = cnt0_q;
  assign frame_count1 = cnt1_q;

endmodule
